imem_arbiter: RTL and testbench

Sequencer and arbiter for the pipelined core's single-port, word-addressed instruction memory. It shares the memory between two requesters. The IF stage fetches instructions. The boot loader writes program words and reads them back. The arbiter holds the core in a BOOT phase until loading completes, then gives fetch priority, with a wait counter so the loader is never starved. It sits between the IF stage / loader and the memory array, which has a 1-cycle synchronous read.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/arb_wait_counter.sv | 38 +++
 rtl/imem_arbiter.sv | 127 ++++++++++++
 tb/tb_imem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core package: instruction-memory sizing, arbiter state and owner-tag encoding.
// IMEM_ARB_DEBUG_EN widens the owner tag to make room for the debug requester.
package riscv_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic {
        ARB_BOOT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

`ifdef IMEM_ARB_DEBUG_EN
    localparam int OWN_W = 2;
`else
    localparam int OWN_W = 1;
`endif

    typedef logic [OWN_W-1:0] own_t;

    localparam own_t OWN_FETCH = own_t'(0);
    localparam own_t OWN_LOAD  = own_t'(1);
`ifdef IMEM_ARB_DEBUG_EN
    localparam own_t OWN_DBG   = own_t'(2);
`endif

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the loader has been denied the memory.
// sat_hit tells the arbiter the loader must win this cycle.
module arb_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] sat,
    output logic             sat_hit
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: cnt_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != sat)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_hit = (cnt_q == sat);

endmodule

// File: rtl/imem_arbiter.sv
// BOOT/RUN sequencer and arbiter sharing the single-port instruction memory between fetch and loader.
// Optional read-only debug requester when IMEM_ARB_DEBUG_EN is defined.
module imem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
`ifdef IMEM_ARB_DEBUG_EN
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
`endif
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              running
);

    localparam int WAIT_W = 4;

    arb_state_e state_d, state_q;
    logic       rvalid_d, rvalid_q;
    own_t       own_d, own_q;
    logic       sat_hit;

    always_comb begin
        state_d = state_q;
        if ((state_q == ARB_BOOT) && boot_done) begin
            state_d = ARB_RUN;
        end
    end

    assign running = (state_q == ARB_RUN);

    // Fetch is masked in BOOT, which leaves the loader unconditionally granted there.
    assign f_gnt = running && f_req && !(l_req && sat_hit);
    assign l_gnt = l_req && !f_gnt;
`ifdef IMEM_ARB_DEBUG_EN
    assign d_gnt = d_req && !f_gnt && !l_gnt;
`endif

    arb_wait_counter #(
        .CNT_W (WAIT_W)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (running && l_req && !l_gnt),
        .clr     (!running || !l_req || l_gnt),
        .sat     (WAIT_W'(MAX_WAIT)),
        .sat_hit (sat_hit)
    );

    always_comb begin
        m_we    = 1'b0;
        m_addr  = f_addr;
        m_wdata = l_wdata;
        if (l_gnt) begin
            m_we   = l_we;
            m_addr = l_addr;
        end
`ifdef IMEM_ARB_DEBUG_EN
        else if (d_gnt) begin
            m_addr = d_addr;
        end
        m_en = f_gnt | l_gnt | d_gnt;
`else
        m_en = f_gnt | l_gnt;
`endif
    end

    // The owner tag routes next cycle's memory data to whoever issued the read.
    always_comb begin
        rvalid_d = m_en && !m_we;
        own_d    = OWN_LOAD;
        if (f_gnt) begin
            own_d = OWN_FETCH;
        end
`ifdef IMEM_ARB_DEBUG_EN
        else if (d_gnt) begin
            own_d = OWN_DBG;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_BOOT;
            rvalid_q <= 1'b0;
            own_q    <= OWN_FETCH;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            own_q    <= own_d;
        end
    end

    assign f_rvalid = rvalid_q && (own_q == OWN_FETCH);
    assign l_rvalid = rvalid_q && (own_q == OWN_LOAD);
    assign f_rdata  = m_rdata;
    assign l_rdata  = m_rdata;
`ifdef IMEM_ARB_DEBUG_EN
    assign d_rvalid = rvalid_q && (own_q == OWN_DBG);
    assign d_rdata  = m_rdata;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        boot_done = 1'b0;
    logic        f_req = 1'b0;
    logic [9:0]  f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0, l_we = 1'b0;
    logic [9:0]  l_addr = '0;
    logic [31:0] l_wdata = '0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        d_req = 1'b0;
    logic [9:0]  d_addr = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        running;

    int total = 0;
    int bad   = 0;

    imem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .boot_done(boot_done),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
`ifdef IMEM_ARB_DEBUG_EN
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`endif
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .running(running)
    );

`ifndef IMEM_ARB_DEBUG_EN
    assign d_gnt    = 1'b0;
    assign d_rvalid = 1'b0;
    assign d_rdata  = '0;
`endif

    always #5 clk = ~clk;

    // Memory array with 1-cycle synchronous read.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    // Reference model.
    bit          mdl_run;
    int          mdl_deny;
    int          mdl_pend;       // 0 none, 1 fetch, 2 loader, 3 debug
    logic [31:0] mdl_pend_data;
    logic [31:0] ref_mem [1024];
    bit          e_fg, e_lg, e_dg, e_en, e_we;
    logic [9:0]  e_addr;

    task automatic predict();
        e_fg = 0; e_lg = 0; e_dg = 0;
        if (mdl_run && f_req && !(l_req && mdl_deny >= MAX_WAIT)) e_fg = 1;
        else e_lg = l_req;
        e_dg   = d_req && !e_fg && !e_lg;
        e_en   = e_fg || e_lg || e_dg;
        e_we   = e_lg && l_we;
        e_addr = e_fg ? f_addr : (e_lg ? l_addr : d_addr);
    endtask

    task automatic advance();
        mdl_pend = 0;
        if (e_fg) begin
            mdl_pend = 1; mdl_pend_data = ref_mem[f_addr];
        end else if (e_lg && !l_we) begin
            mdl_pend = 2; mdl_pend_data = ref_mem[l_addr];
        end else if (e_lg) begin
            ref_mem[l_addr] = l_wdata;
        end else if (e_dg) begin
            mdl_pend = 3; mdl_pend_data = ref_mem[d_addr];
        end
        if (mdl_run && l_req && !e_lg) mdl_deny++;
        else mdl_deny = 0;
        if (boot_done) mdl_run = 1;
    endtask

    task automatic drive(input logic fr, input logic [9:0] fa, input logic lr, input logic lwe,
                         input logic [9:0] la, input logic [31:0] lwd, input logic bd,
                         input logic dr, input logic [9:0] da);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
        boot_done = bd; d_req = dr; d_addr = da;
        #2;
        predict();
    endtask

    task automatic tick();
        @(negedge clk);
        advance();
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        f_req = 0; l_req = 0; boot_done = 0; d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        mdl_run = 0; mdl_deny = 0; mdl_pend = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        f_req = 1'b1;
        #2;
        total++;
        if ({f_gnt, l_gnt, m_en, running, f_rvalid, l_rvalid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got gnt_f/gnt_l/en/run/rv_f/rv_l=%b expected 000000",
                     {f_gnt, l_gnt, m_en, running, f_rvalid, l_rvalid});
        end
        do_reset();
        drive(1, 10'd5, 0, 0, '0, '0, 0, 0, '0);
        total++;
        if ({f_gnt, running, f_rvalid, l_rvalid} !== 4'b0) begin
            bad++;
            $display("FAIL boot_fetch_masked got gnt/run/rv_f/rv_l=%b expected 0000",
                     {f_gnt, running, f_rvalid, l_rvalid});
        end
        tick();
    endtask

    task automatic test_boot_load();
        drive(1, 10'd5, 1, 1, 10'd3, 32'h00B62423, 0, 0, '0);
        total++;
        if ({f_gnt, l_gnt, m_en, m_we, running} !== 5'b01110 || m_addr !== 10'd3
            || m_wdata !== 32'h00B62423) begin
            bad++;
            $display("FAIL boot_write got f/l/en/we/run=%b addr=%0d wdata=%h expected 01110 3 00b62423",
                     {f_gnt, l_gnt, m_en, m_we, running}, m_addr, m_wdata);
        end
        tick();
        idle();
        total++;
        if ({f_rvalid, l_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL write_no_rvalid got rv_f/rv_l=%b expected 00", {f_rvalid, l_rvalid});
        end
        tick();
    endtask

    task automatic test_boot_done_fetch();
        // boot_done together with a loader write: still BOOT this cycle
        drive(1, 10'd3, 1, 1, 10'd4, 32'h1234_5678, 1, 0, '0);
        total++;
        if ({f_gnt, l_gnt, running} !== 3'b010) begin
            bad++;
            $display("FAIL boot_done_cycle got f/l/run=%b expected 010", {f_gnt, l_gnt, running});
        end
        tick();
        drive(1, 10'd3, 0, 0, '0, '0, 0, 0, '0);
        total++;
        if ({f_gnt, l_gnt, m_en, m_we, running} !== 5'b10101 || m_addr !== 10'd3) begin
            bad++;
            $display("FAIL run_fetch got f/l/en/we/run=%b addr=%0d expected 10101 3",
                     {f_gnt, l_gnt, m_en, m_we, running}, m_addr);
        end
        tick();
        idle();
        total++;
        if ({f_rvalid, l_rvalid} !== 2'b10 || f_rdata !== 32'h00B62423) begin
            bad++;
            $display("FAIL fetch_return got rv=%b data=%h expected 10 00b62423",
                     {f_rvalid, l_rvalid}, f_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        for (int k = 0; k < 6; k++) begin
            drive(1, 10'd7, (k < 5), 0, 10'd3, '0, 0, 0, '0);
            total++;
            if ({f_gnt, l_gnt} !== {(k != 4), (k == 4)}) begin
                bad++;
                $display("FAIL contention_c%0d got f/l=%b expected %b", k, {f_gnt, l_gnt},
                         {(k != 4), (k == 4)});
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_loader_read();
        drive(0, '0, 1, 0, 10'd0, '0, 0, 0, '0);
        total++;
        if ({f_gnt, l_gnt, m_en, m_we} !== 4'b0110 || m_addr !== 10'd0) begin
            bad++;
            $display("FAIL loader_read_gnt got f/l/en/we=%b addr=%0d expected 0110 0",
                     {f_gnt, l_gnt, m_en, m_we}, m_addr);
        end
        tick();
        idle();
        total++;
        if ({f_rvalid, l_rvalid} !== 2'b01 || l_rdata !== mdl_pend_data) begin
            bad++;
            $display("FAIL loader_read_ret got rv=%b data=%h expected 01 %h",
                     {f_rvalid, l_rvalid}, l_rdata, mdl_pend_data);
        end
        tick();
    endtask

    task automatic test_random();
        logic fr = 0, lr = 0, lwe = 0, dr = 0;
        logic [9:0]  fa = '0, la = '0, da = '0;
        logic [31:0] lwd = '0;
        logic [31:0] got_d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!fr) begin fr = ($urandom_range(0, 2) != 0); fa = 10'($urandom_range(0, 15)); end
            if (!lr) begin
                lr = ($urandom_range(0, 2) == 0); lwe = 1'($urandom_range(0, 1));
                la = 10'($urandom_range(0, 15)); lwd = $urandom;
            end
`ifdef IMEM_ARB_DEBUG_EN
            if (!dr) begin dr = ($urandom_range(0, 3) == 0); da = 10'($urandom_range(0, 15)); end
`endif
            drive(fr, fa, lr, lwe, la, lwd, ($urandom_range(0, 19) == 0), dr, da);
            total++;
            if ({f_gnt, l_gnt, d_gnt} !== {e_fg, e_lg, e_dg}) begin
                bad++;
                $display("FAIL rnd_grant c%0d got f/l/d=%b expected %b", i,
                         {f_gnt, l_gnt, d_gnt}, {e_fg, e_lg, e_dg});
            end
            total++;
            if ({m_en, m_we} !== {e_en, e_we} || (e_en && m_addr !== e_addr)
                || (e_we && m_wdata !== l_wdata)) begin
                bad++;
                $display("FAIL rnd_membus c%0d got en/we=%b addr=%0d wd=%h expected %b %0d %h", i,
                         {m_en, m_we}, m_addr, m_wdata, {e_en, e_we}, e_addr, l_wdata);
            end
            total++;
            if ({f_rvalid, l_rvalid, d_rvalid} !== {mdl_pend == 1, mdl_pend == 2, mdl_pend == 3}
                || running !== mdl_run) begin
                bad++;
                $display("FAIL rnd_rvalid c%0d got rv f/l/d=%b run=%b expected pend=%0d run=%b", i,
                         {f_rvalid, l_rvalid, d_rvalid}, running, mdl_pend, mdl_run);
            end
            if (mdl_pend != 0) begin
                got_d = (mdl_pend == 1) ? f_rdata : (mdl_pend == 2) ? l_rdata : d_rdata;
                total++;
                if (got_d !== mdl_pend_data) begin
                    bad++;
                    $display("FAIL rnd_rdata c%0d got %h expected %h", i, got_d, mdl_pend_data);
                end
            end
            if (e_fg) fr = 0;
            if (e_lg) lr = 0;
            if (e_dg) dr = 0;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(0, '0, 0, 0, '0, '0, 1, 0, '0);
        tick();
        drive(1, 10'd3, 0, 0, '0, '0, 0, 0, '0);
        tick();
        idle();
        total++;
        if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[3]) begin
            bad++;
            $display("FAIL pre_reset_read got rv=%b data=%h expected 1 %h", f_rvalid, f_rdata, ref_mem[3]);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({f_rvalid, l_rvalid, running} !== 3'b000) begin
            bad++;
            $display("FAIL async_drop got rv_f/rv_l/run=%b expected 000", {f_rvalid, l_rvalid, running});
        end
        @(negedge clk);
        rst = 1'b0;
        mdl_run = 0; mdl_deny = 0; mdl_pend = 0;
        drive(1, 10'd3, 0, 0, '0, '0, 1, 0, '0);
        total++;
        if ({f_gnt, f_rvalid, l_rvalid, running} !== 4'b0000) begin
            bad++;
            $display("FAIL post_reset got f/rv_f/rv_l/run=%b expected 0000",
                     {f_gnt, f_rvalid, l_rvalid, running});
        end
        tick();
        // a cleared wait counter lets fetch win the first contended cycle
        drive(1, 10'd3, 1, 0, 10'd1, '0, 0, 0, '0);
        total++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL wait_cleared got f/l=%b expected 10", {f_gnt, l_gnt});
        end
        tick();
        idle();
        tick();
    endtask

`ifdef IMEM_ARB_DEBUG_EN
    task automatic test_debug();
        drive(1, 10'd2, 0, 0, '0, '0, 0, 1, 10'd3);
        total++;
        if ({f_gnt, d_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL dbg_lowest got f/d=%b expected 10", {f_gnt, d_gnt});
        end
        tick();
        drive(0, '0, 0, 0, '0, '0, 0, 1, 10'd3);
        total++;
        if (d_gnt !== 1'b1 || m_addr !== 10'd3) begin
            bad++;
            $display("FAIL dbg_alone got gnt=%b addr=%0d expected 1 3", d_gnt, m_addr);
        end
        tick();
        idle();
        total++;
        if ({f_rvalid, l_rvalid, d_rvalid} !== 3'b001 || d_rdata !== ref_mem[3]) begin
            bad++;
            $display("FAIL dbg_return got rv=%b data=%h expected 001 %h",
                     {f_rvalid, l_rvalid, d_rvalid}, d_rdata, ref_mem[3]);
        end
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA500_0000 ^ (i * 32'h0001_0203);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
        end
        mdl_run = 0; mdl_deny = 0; mdl_pend = 0; mdl_pend_data = '0;
        test_reset();
        test_boot_load();
        test_boot_done_fetch();
        test_contention();
        test_loader_read();
`ifdef IMEM_ARB_DEBUG_EN
        test_debug();
`endif
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
